// File: rtl/otg_bus_responder.sv
// otg_bus_responder: peripheral end of the 16-bit OTG host bus. Two banks of
// 16x16 registers sit behind command/data ports; each bank drives a level interrupt.
module otg_bank #(
  parameter int AUTO_INC = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        idx_ld,
  input  logic [3:0]  idx_val,
  input  logic        idx_inc,
  input  logic        wr_en,
  input  logic [15:0] wdata,
  input  logic [15:0] irq_set,
  input  logic [3:0]  loc_addr,
  output logic [15:0] loc_data,
  output logic [15:0] rdata,
  output logic [3:0]  idx,
  output logic        irq
);
  logic [15:0][15:0] regs;
  logic [15:0]       w1c;
  logic [3:0]        step;

  assign step     = 4'(AUTO_INC);
  assign w1c      = (wr_en && idx == 4'd0) ? wdata : '0;
  assign rdata    = regs[idx];
  assign loc_data = regs[loc_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
      idx  <= '0;
      irq  <= 1'b0;
    end else if (clr) begin
      regs <= '0;
      idx  <= '0;
      irq  <= 1'b0;
    end else begin
      // A new cause in the same cycle as its write-1-to-clear survives.
      regs[0] <= (regs[0] & ~w1c) | irq_set;
      for (int i = 1; i < 16; i++)
        if (wr_en && idx == 4'(i)) regs[i] <= wdata;
      if (idx_ld)       idx <= idx_val;
      else if (idx_inc) idx <= idx + step;
      irq <= |(regs[0] & regs[1]);
    end
  end
endmodule

module otg_bus_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int AUTO_INC    = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  inout  wire  [15:0] OTG_DATA,
  input  logic [1:0]  OTG_ADDR,
  input  logic        OTG_CS_N,
  input  logic        OTG_RD_N,
  input  logic        OTG_WR_N,
  input  logic        OTG_RST_N,
  output logic        OTG_INT0,
  output logic        OTG_INT1,
  input  logic [15:0] irq_set_hc,
  input  logic [15:0] irq_set_dc,
  input  logic        loc_bank,
  input  logic [3:0]  loc_addr,
  output logic [15:0] loc_rdata,
  output logic        acc_pulse
);
  typedef struct packed {
    logic        rst_n;
    logic        cs_n;
    logic        rd_n;
    logic        wr_n;
    logic [1:0]  addr;
    logic [15:0] data;
  } bus_s_t;

  typedef enum logic [1:0] {IDLE, WR_ACT, RD_ACT, RD_REL} state_t;

  localparam bus_s_t SYNC_RST = '{rst_n: 1'b1, cs_n: 1'b1, rd_n: 1'b1, wr_n: 1'b1,
                                  addr: 2'b00, data: 16'h0000};

  bus_s_t [SYNC_STAGES-1:0] sync_q;
  bus_s_t                   s;
  logic [2:0]               prev_q;  // {cs_n, rd_n, wr_n} one clk earlier
  logic rd_fall_q, rd_rise_q, wr_fall_q, wr_rise_q, cs_rise_q;

  state_t      st_q, st_d;
  logic        load_rd, rd_done, wr_commit, set_err, clr_err;
  logic        oe_q, acc_q, bus_err_q;
  logic [15:0] dout_q, cap_data, rd_val;
  logic [1:0]  cap_addr, rd_addr;

  logic [1:0][15:0] bk_rdata, bk_loc, bk_set;
  logic [1:0][3:0]  bk_idx;
  logic [1:0]       bk_irq, bk_idx_ld, bk_inc, bk_wr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= {SYNC_STAGES{SYNC_RST}};
    else          sync_q <= {sync_q[SYNC_STAGES-2:0],
                             {OTG_RST_N, OTG_CS_N, OTG_RD_N, OTG_WR_N, OTG_ADDR, OTG_DATA}};
  end
  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q    <= 3'b111;
      rd_fall_q <= 1'b0;
      rd_rise_q <= 1'b0;
      wr_fall_q <= 1'b0;
      wr_rise_q <= 1'b0;
      cs_rise_q <= 1'b0;
    end else begin
      prev_q    <= {s.cs_n, s.rd_n, s.wr_n};
      cs_rise_q <= ~prev_q[2] &  s.cs_n;
      rd_fall_q <=  prev_q[1] & ~s.rd_n;
      rd_rise_q <= ~prev_q[1] &  s.rd_n;
      wr_fall_q <=  prev_q[0] & ~s.wr_n;
      wr_rise_q <= ~prev_q[0] &  s.wr_n;
    end
  end

  assign rd_val = s.addr[0] ? {bus_err_q, 11'b0, bk_idx[s.addr[1]]} : bk_rdata[s.addr[1]];

  always_comb begin
    st_d      = st_q;
    load_rd   = 1'b0;
    rd_done   = 1'b0;
    wr_commit = 1'b0;
    set_err   = 1'b0;
    clr_err   = 1'b0;
    bk_idx_ld = '0;
    bk_inc    = '0;
    bk_wr     = '0;
    case (st_q)
      IDLE: begin
        if (!s.cs_n && !s.rd_n && !s.wr_n) set_err = 1'b1;
        else if (!s.cs_n && wr_fall_q)     st_d = WR_ACT;
        else if (!s.cs_n && rd_fall_q) begin
          st_d    = RD_ACT;
          load_rd = 1'b1;
        end
      end
      WR_ACT: begin
        if (rd_fall_q) set_err = 1'b1;
        if (wr_rise_q || cs_rise_q) begin
          st_d      = IDLE;
          wr_commit = 1'b1;
        end
      end
      RD_ACT: begin
        if (wr_fall_q) set_err = 1'b1;
        if (rd_rise_q || cs_rise_q) begin
          st_d    = RD_REL;
          rd_done = 1'b1;
        end
      end
      default: st_d = IDLE;
    endcase
    if (wr_commit) begin
      if (cap_addr[0]) bk_idx_ld[cap_addr[1]] = 1'b1;
      else begin
        bk_wr[cap_addr[1]]  = 1'b1;
        bk_inc[cap_addr[1]] = 1'b1;
      end
    end
    if (rd_done) begin
      if (rd_addr[0]) clr_err = ~rd_addr[1];
      else            bk_inc[rd_addr[1]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q      <= IDLE;
      oe_q      <= 1'b0;
      acc_q     <= 1'b0;
      bus_err_q <= 1'b0;
      dout_q    <= '0;
      cap_data  <= '0;
      cap_addr  <= '0;
      rd_addr   <= '0;
    end else if (!s.rst_n) begin
      st_q      <= IDLE;
      oe_q      <= 1'b0;
      acc_q     <= 1'b0;
      bus_err_q <= 1'b0;
      dout_q    <= '0;
      cap_data  <= '0;
      cap_addr  <= '0;
      rd_addr   <= '0;
    end else begin
      st_q  <= st_d;
      acc_q <= wr_commit | rd_done;
      // Keep the last values seen while the write strobe was low.
      if (!s.cs_n && !s.wr_n) begin
        cap_addr <= s.addr;
        cap_data <= s.data;
      end
      if (load_rd) begin
        rd_addr <= s.addr;
        dout_q  <= rd_val;
        oe_q    <= 1'b1;
      end else if (rd_done) begin
        oe_q <= 1'b0;
      end
      if (set_err)      bus_err_q <= 1'b1;
      else if (clr_err) bus_err_q <= 1'b0;
    end
  end

  assign bk_set = {irq_set_dc, irq_set_hc};

  for (genvar b = 0; b < 2; b++) begin : g_bank
    otg_bank #(.AUTO_INC(AUTO_INC)) u_bank (
      .clk      (clk),
      .rst_n    (reset_n),
      .clr      (~s.rst_n),
      .idx_ld   (bk_idx_ld[b]),
      .idx_val  (cap_data[3:0]),
      .idx_inc  (bk_inc[b]),
      .wr_en    (bk_wr[b]),
      .wdata    (cap_data),
      .irq_set  (bk_set[b]),
      .loc_addr (loc_addr),
      .loc_data (bk_loc[b]),
      .rdata    (bk_rdata[b]),
      .idx      (bk_idx[b]),
      .irq      (bk_irq[b])
    );
  end

  assign OTG_DATA  = oe_q ? dout_q : 'z;
  assign OTG_INT0  = bk_irq[0];
  assign OTG_INT1  = bk_irq[1];
  assign loc_rdata = bk_loc[loc_bank];
  assign acc_pulse = acc_q;
endmodule
